main_mem_responder: RTL

- Memory-side responder for the main-memory valid/ready interface driven by the load/store exec elements.
- Write channel (main_mem_in_*) and read channel (main_mem_out_*) are backed by an on-chip word array with configurable response latency.
- Serves one request at a time and arbitrates between simultaneous read and write requests.
- Sits between the exec-element mux and on-chip block RAM.

---
 rtl/main_mem_pkg.sv | 34 +++
 rtl/main_mem_array.sv | 51 +++++
 rtl/main_mem_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/main_mem_pkg.sv
// Shared types and constants for the main-memory responder.
//
// Contents:
//   WORD_W            data word width
//   MAX_LATENCY       largest legal read/write response latency
//   main_mem_state_t  responder FSM state encoding
//   lat_cnt_width()   bits needed to hold a latency count up to a maximum
//   LAT_CNT_W         latency-counter width (4 bits for MAX_LATENCY = 15)
package main_mem_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned MAX_LATENCY = 15;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrBusy = 3'd1,
    StRdBusy = 3'd2,
    StWrResp = 3'd3,
    StRdResp = 3'd4
  } main_mem_state_t;

  // Smallest width w with 2**w > max_lat.
  function automatic int unsigned lat_cnt_width(input int unsigned max_lat);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) <= max_lat) begin
      w++;
    end
    return w;
  endfunction

  localparam int unsigned LAT_CNT_W = lat_cnt_width(MAX_LATENCY);

endpackage

// File: rtl/main_mem_array.sv
// Single-port word RAM behind the main-memory responder.
//
// Synchronous write and registered read, kept apart from the control FSM so the
// storage maps onto block RAM. The read register only loads when re_i is high,
// so rdata_o holds the last word read until the next read. Only the output
// register is reset; the array contents survive reset.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset (read register only)
//   addr_i   word index
//   we_i     write enable, writes wdata_i at addr_i
//   re_i     read enable, loads mem[addr_i] into the read register
//   wdata_i  write data
//   rdata_o  registered read data
module main_mem_array
  import main_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  localparam int unsigned Depth = 32'd1 << ADDR_W;

  logic [WORD_W-1:0] mem_q [Depth];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder for the exec-element main-memory valid/ready interface.
//
// Serves one request at a time from an on-chip word array. A write commits and
// a read samples the array on the accept edge; the matching ready pulses for
// one cycle LATENCY-1 edges later, so the initiator captures it LATENCY edges
// after accept. Simultaneous requests in IDLE are arbitrated by a 1-bit
// round-robin that flips only on contested cycles (read wins after reset).
//
// Optional feature (macro MAIN_MEM_BOUNDS_CHECK_EN): addresses with any set bit
// above ADDR_W-1 are out of range; such writes are dropped, such reads return
// zero, and bounds_err sets and sticks until reset. Without the macro the upper
// bits are ignored (addresses wrap) and bounds_err is tied low.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   main_mem_in_*       write channel: addr, data, valid in; ready pulse out
//   main_mem_out_*      read channel: addr, valid in; data, ready pulse out
//   bounds_err          sticky out-of-range flag
module main_mem_responder
  import main_mem_pkg::*;
#(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] main_mem_in_addr,
  input  logic [WORD_W-1:0] main_mem_in_data,
  input  logic              main_mem_in_valid,
  output logic              main_mem_in_ready,
  input  logic [WORD_W-1:0] main_mem_out_addr,
  input  logic              main_mem_out_valid,
  output logic [WORD_W-1:0] main_mem_out_data,
  output logic              main_mem_out_ready,
  output logic              bounds_err
);

  localparam logic [LAT_CNT_W-1:0] WrLoad = LAT_CNT_W'(WRITE_LATENCY - 1);
  localparam logic [LAT_CNT_W-1:0] RdLoad = LAT_CNT_W'(READ_LATENCY - 1);

  main_mem_state_t       state_q, state_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  prefer_wr_q, prefer_wr_d;

  logic                  grant_wr, grant_rd;
  logic                  wr_oob;
  logic [ADDR_W-1:0]     arr_addr;
  logic                  arr_we, arr_re;
  logic [WORD_W-1:0]     arr_rdata;

  // Write wins when it is alone or when the round-robin points at it.
  assign grant_wr = main_mem_in_valid & (~main_mem_out_valid | prefer_wr_q);
  assign grant_rd = main_mem_out_valid & ~grant_wr;

  // The array is accessed on the accept edge itself, so nothing needs to be
  // carried across the BUSY cycles except the latency count.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prefer_wr_d = prefer_wr_q;
    arr_addr    = main_mem_out_addr[ADDR_W-1:0];
    arr_we      = 1'b0;
    arr_re      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_wr) begin
          arr_addr = main_mem_in_addr[ADDR_W-1:0];
          arr_we   = ~wr_oob;
          cnt_d    = WrLoad;
          state_d  = (WRITE_LATENCY == 1) ? StWrResp : StWrBusy;
        end else if (grant_rd) begin
          arr_re  = 1'b1;
          cnt_d   = RdLoad;
          state_d = (READ_LATENCY == 1) ? StRdResp : StRdBusy;
        end
        // Only a contested cycle moves the round-robin pointer.
        if (main_mem_in_valid && main_mem_out_valid) begin
          prefer_wr_d = ~prefer_wr_q;
        end
      end
      StWrBusy, StRdBusy: begin
        cnt_d = cnt_q - LAT_CNT_W'(1);
        if (cnt_q == LAT_CNT_W'(1)) begin
          state_d = (state_q == StWrBusy) ? StWrResp : StRdResp;
        end
      end
      StWrResp, StRdResp: begin
        // Initiator drops valid at this edge; back to IDLE unconditionally.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      prefer_wr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prefer_wr_q <= prefer_wr_d;
    end
  end

  assign main_mem_in_ready  = (state_q == StWrResp);
  assign main_mem_out_ready = (state_q == StRdResp);

  main_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .addr_i  (arr_addr),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .wdata_i (main_mem_in_data),
    .rdata_o (arr_rdata)
  );

`ifdef MAIN_MEM_BOUNDS_CHECK_EN
  logic rd_oob;
  logic wr_accept, rd_accept;
  logic rd_oob_q, rd_oob_d;
  logic bounds_err_q, bounds_err_d;

  assign wr_oob    = |main_mem_in_addr[WORD_W-1:ADDR_W];
  assign rd_oob    = |main_mem_out_addr[WORD_W-1:ADDR_W];
  assign wr_accept = (state_q == StIdle) & grant_wr;
  assign rd_accept = (state_q == StIdle) & grant_rd;

  always_comb begin
    rd_oob_d     = rd_oob_q;
    bounds_err_d = bounds_err_q;
    // Remembered per read so the zeroed data stays stable until the next read.
    if (rd_accept) begin
      rd_oob_d = rd_oob;
    end
    if ((wr_accept && wr_oob) || (rd_accept && rd_oob)) begin
      bounds_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_oob_q     <= 1'b0;
      bounds_err_q <= 1'b0;
    end else begin
      rd_oob_q     <= rd_oob_d;
      bounds_err_q <= bounds_err_d;
    end
  end

  assign main_mem_out_data = rd_oob_q ? '0 : arr_rdata;
  assign bounds_err        = bounds_err_q;
`else
  logic unused_upper_addr;

  // Upper address bits are ignored, so out-of-range addresses alias.
  assign wr_oob            = 1'b0;
  assign unused_upper_addr = ^{main_mem_in_addr[WORD_W-1:ADDR_W],
                               main_mem_out_addr[WORD_W-1:ADDR_W]};
  assign main_mem_out_data = arr_rdata;
  assign bounds_err        = 1'b0;
`endif

endmodule
